// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_pkg -- shared constants and helpers for the parameterised sync FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and entry count.
//   ptr_inc                       : circular pointer increment, wraps depth-1 -> 0.
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    if (ptr == (depth - 32'd1)) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if -- handshake/status bundle of the sync FIFO.
//   master : producer/consumer side (drives wr, wdata, rd).
//   slave  : FIFO side (drives rdata, rvalid, status, count, error flags).
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic             rd;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, wdata, rd,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr, wdata, rd,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// fifo_mem_2p -- FIFO storage: one write port, one registered read port.
//   clk, rst      : clock and synchronous active-high reset (read register only).
//   we/waddr/wdata: write port.
//   re/raddr      : read request; rdata loads at the same edge, holds otherwise.
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Storage array write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read: a same-address write in this cycle is not seen (old data returned).
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param -- synchronous circular-buffer FIFO, any depth >= 2.
//   clk : rising-edge clock.   rst : synchronous active-high reset.
//   bus : sync_fifo_param_if.slave -- wr/wdata/rd in; rdata/rvalid (registered,
//         1-cycle latency), full/empty/almost_* (decoded from count), count,
//         sticky overflow/underflow out.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          rvalid_r;
  logic          overflow_r;
  logic          underflow_r;
  logic          full_s;
  logic          empty_s;
  logic          rd_ok_s;
  logic          wr_ok_s;

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {CW{1'b0}});
  assign rd_ok_s = bus.rd && !empty_s;
  // A write into a full FIFO is fine when a read frees the slot at the same edge.
  assign wr_ok_s = bus.wr && (!full_s || rd_ok_s);

  // Occupancy update from the accepted accesses.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count, read-valid pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      rvalid_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= AW'(ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
      end
      if (rd_ok_s) begin
        rd_ptr_r <= AW'(ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));
      end
      count_r     <= count_nxt_s;
      rvalid_r    <= rd_ok_s;
      overflow_r  <= overflow_r  || (bus.wr && full_s && !rd_ok_s);
      underflow_r <= underflow_r || (bus.rd && empty_s);
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok_s),
    .waddr (wr_ptr_r),
    .wdata (bus.wdata),
    .re    (rd_ok_s),
    .raddr (rd_ptr_r),
    .rdata (bus.rdata)
  );

  assign bus.rvalid       = rvalid_r;
  assign bus.count        = count_r;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_r >= AF_C);
  assign bus.almost_empty = (count_r <= AE_C);
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param -- directed self-checking bench, WIDTH=8 DEPTH=5 AF=4 AE=1.
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(5)) bus ();

  sync_fifo_param #(
    .WIDTH    (8),
    .DEPTH    (5),
    .AF_LEVEL (4),
    .AE_LEVEL (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bus.wr    = w;
    bus.wdata = d;
    bus.rd    = r;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    bus.wr    = 1'b0;
    bus.rd    = 1'b0;
    bus.wdata = 8'h00;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);

    // Fill 0x11..0x55
    for (int i = 1; i <= 5; i++) begin
      v = 8'(i * 17);
      cycle(1'b1, v, 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_empty", 32'(bus.empty), 32'd0);
      chk("fill_af", 32'(bus.almost_full), (i >= 4) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(bus.full), (i == 5) ? 32'd1 : 32'd0);
      chk("fill_ae", 32'(bus.almost_empty), (i <= 1) ? 32'd1 : 32'd0);
    end

    // Drain in order, then one read too many
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("drain_rvalid", 32'(bus.rvalid), 32'd1);
      chk("drain_rdata", 32'(bus.rdata), 32'(i * 17));
      chk("drain_count", 32'(bus.count), 32'(5 - i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_unf_pre", 32'(bus.underflow), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    chk("unf_rvalid", 32'(bus.rvalid), 32'd0);
    chk("unf_rdata", 32'(bus.rdata), 32'h55);
    cycle(1'b0, 8'h00, 1'b0);
    chk("unf_sticky", 32'(bus.underflow), 32'd1);
    do_reset();
    chk("unf_cleared", 32'(bus.underflow), 32'd0);

    // Wrap: write 3, read 3, write 5, read 5
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("wrap_rd_a", 32'(bus.rdata), 32'(i));
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    chk("wrap_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("wrap_rd_b", 32'(bus.rdata), 32'(8'h10 + i));
    end
    chk("wrap_count", 32'(bus.count), 32'd0);

    // Full with simultaneous read+write, then overflow
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    chk("fsim_rvalid", 32'(bus.rvalid), 32'd1);
    chk("fsim_rdata", 32'(bus.rdata), 32'hA1);
    chk("fsim_count", 32'(bus.count), 32'd5);
    chk("fsim_ovf", 32'(bus.overflow), 32'd0);
    cycle(1'b1, 8'hEE, 1'b0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd5);
    chk("ovf_rvalid", 32'(bus.rvalid), 32'd0);
    chk("ovf_rdata", 32'(bus.rdata), 32'hA1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("fsim_drain", 32'(bus.rdata), (i < 4) ? 32'(8'hA2 + i) : 32'hAA);
    end
    chk("fsim_empty", 32'(bus.empty), 32'd1);

    // Read+write while empty: write only
    chk("esim_unf_pre", 32'(bus.underflow), 32'd0);
    cycle(1'b1, 8'h77, 1'b1);
    chk("esim_count", 32'(bus.count), 32'd1);
    chk("esim_unf", 32'(bus.underflow), 32'd1);
    chk("esim_rvalid", 32'(bus.rvalid), 32'd0);
    chk("esim_rdata", 32'(bus.rdata), 32'hAA);
    cycle(1'b0, 8'h00, 1'b1);
    chk("esim_rd", 32'(bus.rdata), 32'h77);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset mid-operation overrides rd/wr
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    chk("mid_count_pre", 32'(bus.count), 32'd3);
    rst = 1'b1;
    cycle(1'b1, 8'h99, 1'b1);
    rst = 1'b0;
    chk("mid_count", 32'(bus.count), 32'd0);
    chk("mid_empty", 32'(bus.empty), 32'd1);
    chk("mid_rvalid", 32'(bus.rvalid), 32'd0);
    chk("mid_ovf", 32'(bus.overflow), 32'd0);
    chk("mid_unf", 32'(bus.underflow), 32'd0);
    chk("mid_rdata", 32'(bus.rdata), 32'd0);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("post_rst_rd", 32'(bus.rdata), 32'h42);
    chk("post_rst_rvalid", 32'(bus.rvalid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
